// File: rtl/led_pwm_driver.sv
// Per-channel PWM LED driver feeding iCE40 SB_IO pads.
// Duty words arrive over valid/ready and are double-buffered so that new
// values only take effect at PWM period boundaries. Each pad gets a
// registered OUTPUT_ENABLE / D_OUT_0 pair in push-pull or open-drain style.
module led_pwm_driver #(
  parameter int NCH      = 4,
  parameter int DW       = 8,
  parameter int PRESCALE = 94
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NCH-1:0]    od_mode,
  input  logic [NCH*DW-1:0] duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic [NCH-1:0]    pad_oe,
  output logic [NCH-1:0]    pad_dout,
  output logic              period_start
);

  localparam logic [15:0]   PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [DW-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  logic [15:0]       r_pre_cnt;
  logic [DW-1:0]     r_pwm_cnt;
  logic              r_period_start;
  logic [NCH*DW-1:0] r_pending;
  logic [NCH*DW-1:0] r_active;
  logic [NCH-1:0]    r_pad_oe;
  logic [NCH-1:0]    r_pad_dout;
  state_t            r_state;
  state_t            w_state_next;

  logic              w_tick;
  logic              w_boundary;
  logic              w_load_pending;
  logic              w_load_active;
  logic [NCH-1:0]    w_on;

  // A tick only exists while running; en=0 freezes everything downstream.
  assign w_tick     = en && (r_pre_cnt == PRE_MAX);
  assign w_boundary = w_tick && (r_pwm_cnt == CNT_MAX);

  // Prescaler: counts 0..PRESCALE-1 while enabled, holds when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
    end else if (en) begin
      r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
    end
  end

  // PWM counter advances one step per tick and wraps naturally at 2^DW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt      <= '0;
      r_period_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      r_period_start <= w_boundary;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake next-state: accept only when empty; promote only when full,
  // so a boundary coinciding with an accept leaves active untouched.
  always_comb begin
    w_state_next   = r_state;
    w_load_pending = 1'b0;
    w_load_active  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (duty_valid) begin
          w_load_pending = 1'b1;
          w_state_next   = S_FULL;
        end
      end
      S_FULL: begin
        if (w_boundary) begin
          w_load_active = 1'b1;
          w_state_next  = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // Pending/active duty double buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      if (w_load_pending) begin
        r_pending <= duty_in;
      end
      if (w_load_active) begin
        r_active <= r_pending;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] w_duty;
      assign w_duty = r_active[gi*DW +: DW];
      // Full-scale duty is treated as always-on so that 100% is reachable.
      assign w_on[gi] = (w_duty == CNT_MAX) || (r_pwm_cnt < w_duty);

      // Registered pad drive: push-pull drives the level, open-drain
      // pulls low when on and floats when off; disabled means tristate.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pad_oe[gi]   <= 1'b0;
          r_pad_dout[gi] <= 1'b0;
        end else if (!en) begin
          r_pad_oe[gi]   <= 1'b0;
          r_pad_dout[gi] <= 1'b0;
        end else if (od_mode[gi]) begin
          r_pad_oe[gi]   <= w_on[gi];
          r_pad_dout[gi] <= 1'b0;
        end else begin
          r_pad_oe[gi]   <= 1'b1;
          r_pad_dout[gi] <= w_on[gi];
        end
      end
    end
  endgenerate

  assign duty_ready   = (r_state == S_EMPTY);
  assign pad_oe       = r_pad_oe;
  assign pad_dout     = r_pad_dout;
  assign period_start = r_period_start;

endmodule
